imm_encoder: RTL and testbench

Inverse of the core's immediate decode. Takes a signed 32-bit immediate, an immediate format selector and a base instruction word, and scatters the immediate into the format-specific instruction bit fields. Flags immediates the selected format cannot represent. Used by the boot-image/trampoline generator and by the instruction-memory patch path; sits between a valid/ready producer and a valid/ready consumer as a 2-stage pipeline.

---
 rtl/imm_encoder_if.sv | 27 ++
 rtl/imm_encoder.sv | 107 ++++++++++
 tb/tb_imm_encoder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/imm_encoder_if.sv
// Valid/ready bus for imm_encoder: the input beat (format, immediate, base word)
// travels upstream->encoder and the encoded word travels encoder->downstream.
interface imm_encoder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  valid_i;
  logic                  ready_o;
  logic [2:0]            ImmSrc_i;
  logic [DATA_WIDTH-1:0] Imm_i;
  logic [DATA_WIDTH-1:0] BaseInstr_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [DATA_WIDTH-1:0] Instr_o;
  logic                  RangeErr_o;
  logic [CNT_WIDTH-1:0]  ErrCount_o;

  modport slave (
    input  valid_i, ImmSrc_i, Imm_i, BaseInstr_i, ready_i,
    output ready_o, valid_o, Instr_o, RangeErr_o, ErrCount_o
  );

  modport master (
    output valid_i, ImmSrc_i, Imm_i, BaseInstr_i, ready_i,
    input  ready_o, valid_o, Instr_o, RangeErr_o, ErrCount_o
  );
endinterface

// File: rtl/imm_encoder.sv
// Scatters a signed immediate into the I/S/B/U/J fields of a base instruction word;
// 2-stage valid/ready pipeline. Optional error counter: define IMM_ERR_COUNT_EN.
module imm_encoder #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input logic         clk_i,
  input logic         rst_ni,
  imm_encoder_if.slave bus
);
  localparam logic [2:0] SRC_I = 3'b000;
  localparam logic [2:0] SRC_B = 3'b001;
  localparam logic [2:0] SRC_S = 3'b010;
  localparam logic [2:0] SRC_U = 3'b011;
  localparam logic [2:0] SRC_J = 3'b100;

  typedef struct packed {
    logic [2:0]            src;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] base;
  } req_t;

  // vld_pipe[1]: stage-1 (request) valid, vld_pipe[2]: stage-2 (result) valid
  logic [2:1]            vld_pipe;
  req_t                  s1_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic                  err_q;
  logic                  s1_advance;
  logic                  in_xfer;
  logic [DATA_WIDTH-1:0] enc_instr;
  logic                  enc_err;

  assign s1_advance  = !vld_pipe[2] || bus.ready_i;
  assign bus.ready_o = !vld_pipe[1] || s1_advance;
  assign in_xfer     = bus.valid_i && bus.ready_o;

  always_comb begin
    enc_instr = s1_q.base;
    enc_err   = 1'b0;
    case (s1_q.src)
      SRC_I: begin
        enc_instr[31:20] = s1_q.imm[11:0];
        enc_err = !((&s1_q.imm[31:11]) || !(|s1_q.imm[31:11]));
      end
      SRC_S: begin
        enc_instr[31:25] = s1_q.imm[11:5];
        enc_instr[11:7]  = s1_q.imm[4:0];
        enc_err = !((&s1_q.imm[31:11]) || !(|s1_q.imm[31:11]));
      end
      SRC_B: begin
        enc_instr[31]    = s1_q.imm[12];
        enc_instr[7]     = s1_q.imm[11];
        enc_instr[30:25] = s1_q.imm[10:5];
        enc_instr[11:8]  = s1_q.imm[4:1];
        enc_err = !((&s1_q.imm[31:12]) || !(|s1_q.imm[31:12])) || s1_q.imm[0];
      end
      SRC_U: begin
        enc_instr[31:12] = s1_q.imm[31:12];
        enc_err = |s1_q.imm[11:0];
      end
      SRC_J: begin
        enc_instr[31]    = s1_q.imm[20];
        enc_instr[19:12] = s1_q.imm[19:12];
        enc_instr[20]    = s1_q.imm[11];
        enc_instr[30:21] = s1_q.imm[10:1];
        enc_err = !((&s1_q.imm[31:20]) || !(|s1_q.imm[31:20])) || s1_q.imm[0];
      end
      default: enc_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      instr_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (bus.ready_o) vld_pipe[1] <= bus.valid_i;
      if (in_xfer) s1_q <= '{src: bus.ImmSrc_i, imm: bus.Imm_i, base: bus.BaseInstr_i};
      if (s1_advance) vld_pipe[2] <= vld_pipe[1];
      // result registers only move when a real beat advances, so a stall holds them
      if (s1_advance && vld_pipe[1]) begin
        instr_q <= enc_instr;
        err_q   <= enc_err;
      end
    end
  end

  assign bus.valid_o    = vld_pipe[2];
  assign bus.Instr_o    = instr_q;
  assign bus.RangeErr_o = err_q;

`ifdef IMM_ERR_COUNT_EN
  logic [CNT_WIDTH-1:0] err_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_cnt_q <= '0;
    else if (vld_pipe[2] && bus.ready_i && err_q && !(&err_cnt_q))
      err_cnt_q <= err_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  assign bus.ErrCount_o = err_cnt_q;
`else
  assign bus.ErrCount_o = '0;
`endif
endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed plan vectors, stall/reset scenarios and
// randomized traffic scored against an arithmetic reference model.
module tb_imm_encoder;
  logic clk_i = 1'b0;
  logic rst_ni;

  imm_encoder_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) bus ();
  imm_encoder #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t        expq[$];
  int          tests = 0;
  int          fails = 0;
  int          cnt_model = 0;
  logic        held = 1'b0;
  logic [31:0] prev_instr;
  logic        prev_err;
  logic        saw_stall_ready_low;
  int          sent, got;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: field placement by shift/mask arithmetic, range by signed bounds.
  function automatic exp_t model(input logic [2:0] src, input logic [31:0] imm,
                                 input logic [31:0] base);
    exp_t        r;
    logic [31:0] mask, f;
    longint      s;
    s = longint'($signed(imm));
    mask = 32'h0;
    f = 32'h0;
    r.err = 1'b1;
    case (src)
      3'd0: begin
        mask = 32'hFFF0_0000; f = imm << 20;
        r.err = !(s >= -2048 && s <= 2047);
      end
      3'd2: begin
        mask = 32'hFE00_0F80; f = (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
        r.err = !(s >= -2048 && s <= 2047);
      end
      3'd1: begin
        mask = 32'hFE00_0F80;
        f = (((imm >> 12) & 1) << 31) | (((imm >> 11) & 1) << 7) |
            (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8);
        r.err = !(s >= -4096 && s <= 4095) || (imm % 2 != 0);
      end
      3'd3: begin
        mask = 32'hFFFF_F000; f = imm;
        r.err = (imm % 4096) != 0;
      end
      3'd4: begin
        mask = 32'hFFFF_F000;
        f = (((imm >> 20) & 1) << 31) | (((imm >> 12) & 32'hFF) << 12) |
            (((imm >> 11) & 1) << 20) | (((imm >> 1) & 32'h3FF) << 21);
        r.err = !(s >= -1048576 && s <= 1048575) || (imm % 2 != 0);
      end
      default: ;
    endcase
    r.instr = (base & ~mask) | (f & mask);
    return r;
  endfunction

  // One clock cycle: drive at negedge, score any output/input transfer, advance.
  task automatic step(input logic v, input logic [2:0] src, input logic [31:0] imm,
                      input logic [31:0] base, input logic rdy);
    exp_t e;
    bus.valid_i = v; bus.ImmSrc_i = src; bus.Imm_i = imm; bus.BaseInstr_i = base;
    bus.ready_i = rdy;
    #1;
    if (held) begin
      chk("stall_valid_held", 32'(bus.valid_o), 32'd1);
      chk("stall_instr_stable", bus.Instr_o, prev_instr);
      chk("stall_err_stable", 32'(bus.RangeErr_o), 32'(prev_err));
    end
    if (bus.valid_o && bus.ready_i) begin
      if (expq.size() == 0) begin
        chk("spurious_output", 32'(bus.valid_o), 32'd0);
      end else begin
        e = expq.pop_front();
        chk("instr", bus.Instr_o, e.instr);
        chk("range_err", 32'(bus.RangeErr_o), 32'(e.err));
`ifdef IMM_ERR_COUNT_EN
        chk("err_count", 32'(bus.ErrCount_o), 32'(cnt_model));
        if (e.err && cnt_model < 65535) cnt_model++;
`else
        chk("err_count", 32'(bus.ErrCount_o), 32'd0);
`endif
      end
      got++;
    end
    held = bus.valid_o && !bus.ready_i;
    prev_instr = bus.Instr_o;
    prev_err = bus.RangeErr_o;
    if (bus.valid_i && bus.ready_o) begin
      expq.push_back(model(src, imm, base));
      sent++;
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (expq.size() != 0 || bus.valid_o); i++)
      step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    chk("drain_empty", 32'(expq.size()), 32'd0);
  endtask

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 4))
      0: return $urandom();
      1: return 32'($urandom_range(0, 8191)) - 32'd4096;
      2: return 32'($urandom_range(0, 4194303)) - 32'd2097152;
      3: return $urandom() & 32'hFFFF_F000;
      default: return {$urandom_range(0, 1) ? 21'h1FFFFF : 21'h0, 11'($urandom())};
    endcase
  endfunction

  initial begin
    logic [31:0] imms [8];
    rst_ni = 1'b0;
    bus.valid_i = 1'b0; bus.ImmSrc_i = '0; bus.Imm_i = '0; bus.BaseInstr_i = '0;
    bus.ready_i = 1'b0;
    sent = 0; got = 0;
    #23;
    chk("rst_valid_o", 32'(bus.valid_o), 32'd0);
    chk("rst_instr_o", bus.Instr_o, 32'h0);
    chk("rst_err_o", 32'(bus.RangeErr_o), 32'd0);
    chk("rst_count_o", 32'(bus.ErrCount_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Known-answer vectors, literal expectations
    step(1'b1, 3'b000, 32'hFFFF_FFFF, 32'h0000_0013, 1'b1);
    chk("lat_cycle1_valid", 32'(bus.valid_o), 32'd0);
    step(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
    chk("lat_cycle2_valid", 32'(bus.valid_o), 32'd1);
    chk("kat_i_neg1", bus.Instr_o, 32'hFFF0_0013);
    chk("kat_i_neg1_err", 32'(bus.RangeErr_o), 32'd0);
    drain();
    step(1'b1, 3'b001, 32'hFFFF_FFFC, 32'h0000_0063, 1'b1);
    step(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
    chk("kat_b_neg4", bus.Instr_o, 32'hFE00_0EE3);
    chk("kat_b_neg4_err", 32'(bus.RangeErr_o), 32'd0);
    drain();
    step(1'b1, 3'b100, 32'h0000_0008, 32'h0000_006F, 1'b1);
    step(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
    chk("kat_j_8", bus.Instr_o, 32'h0080_006F);
    drain();
    step(1'b1, 3'b011, 32'h1234_5000, 32'h0000_00B7, 1'b1);
    step(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
    chk("kat_u", bus.Instr_o, 32'h1234_50B7);
    chk("kat_u_err", 32'(bus.RangeErr_o), 32'd0);
    drain();
    step(1'b1, 3'b000, 32'h0000_0800, 32'h0000_0013, 1'b1);
    step(1'b1, 3'b111, 32'h0000_1234, 32'hDEAD_BEEF, 1'b1);
    chk("kat_i_2048", bus.Instr_o, 32'h8000_0013);
    chk("kat_i_2048_err", 32'(bus.RangeErr_o), 32'd1);
    step(1'b1, 3'b001, 32'h0000_0003, 32'h0000_0063, 1'b1);
    chk("kat_invalid", bus.Instr_o, 32'hDEAD_BEEF);
    chk("kat_invalid_err", 32'(bus.RangeErr_o), 32'd1);
    step(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
    chk("kat_b_odd_err", 32'(bus.RangeErr_o), 32'd1);
    drain();

    // 8 back-to-back beats, downstream stalled in cycles 3..6
    for (int i = 0; i < 8; i++) imms[i] = rand_imm();
    saw_stall_ready_low = 1'b0;
    sent = 0; got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      bus.ready_i = !(c >= 3 && c <= 6);
      #1;
      if (!bus.ready_o) saw_stall_ready_low = 1'b1;
      step(sent < 8, 3'(sent % 5), imms[sent % 8], 32'h0000_0013 + 32'(sent), !(c >= 3 && c <= 6));
    end
    chk("stall_ready_fell", 32'(saw_stall_ready_low), 32'd1);
    chk("stall_sent", 32'(sent), 32'd8);
    chk("stall_got", 32'(got), 32'd8);
    drain();

    // Reset with both stages full drops in-flight beats
    step(1'b1, 3'd0, 32'd5, 32'h13, 1'b0);
    step(1'b1, 3'd0, 32'd6, 32'h13, 1'b0);
    chk("prerst_valid", 32'(bus.valid_o), 32'd1);
    chk("prerst_ready", 32'(bus.ready_o), 32'd0);
    rst_ni = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.valid_o), 32'd0);
    chk("midrst_instr", bus.Instr_o, 32'h0);
    chk("midrst_count", 32'(bus.ErrCount_o), 32'd0);
    expq.delete();
    held = 1'b0;
    cnt_model = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(1'b1, 3'd4, 32'hFFFF_FFF0, 32'h0000_006F, 1'b1);
    chk("postrst_lat1", 32'(bus.valid_o), 32'd0);
    step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    chk("postrst_lat2", 32'(bus.valid_o), 32'd1);
    drain();

    // Randomized traffic with random backpressure
    for (int c = 0; c < 400; c++)
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), rand_imm(), $urandom(),
           $urandom_range(0, 9) < 7);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL timeout reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end
endmodule
